// File: rtl/access_control_pkg.sv
// ---------------------------------------------------------------------------
// access_control_pkg
// Shared definitions for the password access controller: FSM state encoding,
// the command bit position inside the 17-bit user word and default parameter
// values.
// ---------------------------------------------------------------------------
package access_control_pkg;

   // Controller states; encoding is fixed so external debug tools can decode it
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ     = 3'd1,
      MEM_WAIT = 3'd2,
      COMPARE  = 3'd3,
      GRANT    = 3'd4,
      WRITE_PW = 3'd5,
      LOCKOUT  = 3'd6
   } state_e;

   // Bit of the user word that selects "change password" (1) vs attempt/logout (0)
   localparam int CMD_BIT = 16;

   // Default parameter values
   localparam logic [15:0] DEF_PW_ADDR     = 16'h0000;
   localparam int          DEF_MAX_FAILS   = 3;
   localparam int          DEF_LOCK_CYCLES = 16;

   // True when the user word carries the change-password command
   function automatic logic is_change_cmd(input logic [16:0] word);
      return word[CMD_BIT];
   endfunction

endpackage

// File: rtl/access_control_fsm.sv
// ---------------------------------------------------------------------------
// access_control_fsm
// Password-based access controller. A user password attempt is compared
// against the password stored at PW_ADDR in an external synchronous RAM.
// A match grants access; consecutive mismatches are counted and MAX_FAILS of
// them lock the controller out for LOCK_CYCLES cycles. While access is
// granted the stored password can be rewritten through the RAM write port.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   _Data_In         [16] command (0 attempt/logout, 1 change pw), [15:0] value
//   _Data_In_Load    one-cycle strobe qualifying _Data_In
//   _Memory_Data_In  RAM read data, valid one cycle after Address
//   Access_Grant     high while access is granted (GRANT / WRITE_PW)
//   Address          RAM address, constant PW_ADDR
//   wren             RAM write enable, high only in WRITE_PW
//   Data_Out         RAM write data, new password in WRITE_PW, else 0
// ---------------------------------------------------------------------------
module access_control_fsm
   import access_control_pkg::*;
#(
   parameter logic [15:0] PW_ADDR     = DEF_PW_ADDR,
   parameter int          MAX_FAILS   = DEF_MAX_FAILS,
   parameter int          LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] _Data_In,
   input  logic        _Data_In_Load,
   input  logic [15:0] _Memory_Data_In,
   output logic        Access_Grant,
   output logic [15:0] Address,
   output logic        wren,
   output logic [15:0] Data_Out
);

   // Lock counter only has to hold LOCK_CYCLES-1
   localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);
   localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAILS);

   state_e          state_q,    state_d;
   logic [1:0]      fail_cnt_q, fail_cnt_d;
   logic [15:0]     pw_user_q,  pw_user_d;
   logic [15:0]     pw_mem_q,   pw_mem_d;
   logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
   logic            grant_q;
   logic            wren_q;
   logic [15:0]     data_out_q;
   logic [1:0]      fail_inc_s;

   assign fail_inc_s = fail_cnt_q + 2'd1;

   // Next-state and datapath decode
   always_comb begin
      state_d    = state_q;
      fail_cnt_d = fail_cnt_q;
      pw_user_d  = pw_user_q;
      pw_mem_d   = pw_mem_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         IDLE: begin
            // Change-password requests are meaningless without a grant
            if (_Data_In_Load && !is_change_cmd(_Data_In)) begin
               pw_user_d = _Data_In[15:0];
               state_d   = READ;
            end else begin
               state_d   = IDLE;
            end
         end
         READ: begin
            state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            pw_mem_d = _Memory_Data_In;
            state_d  = COMPARE;
         end
         COMPARE: begin
            if (pw_user_q == pw_mem_q) begin
               fail_cnt_d = 2'd0;
               state_d    = GRANT;
            end else begin
               fail_cnt_d = fail_inc_s;
               if (fail_inc_s == FAIL_MAX) begin
                  lock_cnt_d = LOCK_LOAD;
                  state_d    = LOCKOUT;
               end else begin
                  state_d    = IDLE;
               end
            end
         end
         GRANT: begin
            if (_Data_In_Load) begin
               if (is_change_cmd(_Data_In)) begin
                  pw_user_d = _Data_In[15:0];
                  state_d   = WRITE_PW;
               end else begin
                  state_d   = IDLE;
               end
            end else begin
               state_d = GRANT;
            end
         end
         WRITE_PW: begin
            state_d = GRANT;
         end
         LOCKOUT: begin
            // Counter starts at LOCK_CYCLES-1 so the state lasts LOCK_CYCLES cycles
            if (lock_cnt_q == {LW{1'b0}}) begin
               fail_cnt_d = 2'd0;
               state_d    = IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - {{(LW-1){1'b0}}, 1'b1};
               state_d    = LOCKOUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath registers and Moore outputs registered from the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fail_cnt_q <= 2'd0;
         pw_user_q  <= 16'h0000;
         pw_mem_q   <= 16'h0000;
         lock_cnt_q <= {LW{1'b0}};
         grant_q    <= 1'b0;
         wren_q     <= 1'b0;
         data_out_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         fail_cnt_q <= fail_cnt_d;
         pw_user_q  <= pw_user_d;
         pw_mem_q   <= pw_mem_d;
         lock_cnt_q <= lock_cnt_d;
         grant_q    <= (state_d == GRANT) || (state_d == WRITE_PW);
         wren_q     <= (state_d == WRITE_PW);
         data_out_q <= (state_d == WRITE_PW) ? pw_user_d : 16'h0000;
      end
   end

   assign Access_Grant = grant_q;
   assign wren         = wren_q;
   assign Data_Out     = data_out_q;
   assign Address      = PW_ADDR;

endmodule

// File: tb/tb_access_control_fsm.sv
module tb_access_control_fsm;
   import access_control_pkg::*;

   logic        clk;
   logic        rst;
   logic [16:0] data_in;
   logic        data_load;
   logic [15:0] mem_rd;
   logic        grant;
   logic [15:0] addr;
   logic        wren;
   logic [15:0] data_out;

   // RAM model (single word, address always PW_ADDR)
   logic [15:0] ram;
   logic        ram_load;
   logic [15:0] ram_load_val;

   int checks = 0;
   int errors = 0;

   access_control_fsm dut (
      .clk            (clk),
      .rst            (rst),
      ._Data_In       (data_in),
      ._Data_In_Load  (data_load),
      ._Memory_Data_In(mem_rd),
      .Access_Grant   (grant),
      .Address        (addr),
      .wren           (wren),
      .Data_Out       (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_load) ram <= ram_load_val;
      else if (wren) ram <= data_out;
      mem_rd <= ram;
   end

   // Drive one load strobe; call at a negedge, returns at the next negedge
   task automatic load_word(input logic [16:0] w);
      data_in   = w;
      data_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; data_in = 17'h00000; data_load = 1'b0;
      ram_load = 1'b1; ram_load_val = 16'h4789;
      repeat (2) @(negedge clk);
      ram_load = 1'b0;
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++; if (dut.fail_cnt_q !== 2'd0) begin errors++; $display("FAIL reset_fail: got %0d expected 0", dut.fail_cnt_q); end
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", data_out); end
      checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", addr); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mismatch();
      load_word(17'h01476);
      repeat (3) begin
         @(negedge clk);
         checks++; if (grant !== 1'b0) begin errors++; $display("FAIL mismatch_grant: got %b expected 0", grant); end
      end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mismatch_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++; if (dut.fail_cnt_q !== 2'd1) begin errors++; $display("FAIL mismatch_fail: got %0d expected 1", dut.fail_cnt_q); end
      checks++; if (dut.pw_user_q !== 16'h1476) begin errors++; $display("FAIL mismatch_user: got %h expected 1476", dut.pw_user_q); end
      checks++; if (dut.pw_mem_q !== 16'h4789) begin errors++; $display("FAIL mismatch_mem: got %h expected 4789", dut.pw_mem_q); end
   endtask

   task automatic test_match();
      logic [2:0] exp_g;
      exp_g = 3'b100;
      load_word(17'h04789);
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL match_grant_e0: got %b expected 0", grant); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL match_grant_e%0d: got %b expected %b", i + 1, grant, exp_g[i]); end
      end
      checks++; if (dut.fail_cnt_q !== 2'd0) begin errors++; $display("FAIL match_fail: got %0d expected 0", dut.fail_cnt_q); end
      checks++; if (dut.state_q !== GRANT) begin errors++; $display("FAIL match_state: got %0d expected %0d", dut.state_q, GRANT); end
   endtask

   task automatic test_change_pw();
      load_word(17'h1ABCD);
      checks++; if (wren !== 1'b1) begin errors++; $display("FAIL chg_wren: got %b expected 1", wren); end
      checks++; if (data_out !== 16'hABCD) begin errors++; $display("FAIL chg_dout: got %h expected abcd", data_out); end
      checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL chg_addr: got %h expected 0000", addr); end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL chg_grant_wr: got %b expected 1", grant); end
      @(negedge clk);
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL chg_wren_after: got %b expected 0", wren); end
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL chg_dout_after: got %h expected 0000", data_out); end
      checks++; if (dut.state_q !== GRANT) begin errors++; $display("FAIL chg_state_after: got %0d expected %0d", dut.state_q, GRANT); end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL chg_grant_after: got %b expected 1", grant); end
      checks++; if (ram !== 16'hABCD) begin errors++; $display("FAIL chg_ram: got %h expected abcd", ram); end
      load_word(17'h00000);
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL logout_grant: got %b expected 0", grant); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL logout_state: got %0d expected %0d", dut.state_q, IDLE); end
   endtask

   task automatic test_lockout();
      int n;
      for (int a = 1; a <= 3; a++) begin
         load_word({1'b0, 16'(a)});
         repeat (3) @(negedge clk);
         if (a < 3) begin
            checks++; if (dut.fail_cnt_q !== 2'(a)) begin errors++; $display("FAIL lock_fail_%0d: got %0d expected %0d", a, dut.fail_cnt_q, a); end
            checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL lock_idle_%0d: got %0d expected %0d", a, dut.state_q, IDLE); end
         end
      end
      checks++; if (dut.state_q !== LOCKOUT) begin errors++; $display("FAIL lock_enter: got %0d expected %0d", dut.state_q, LOCKOUT); end
      n = 1;
      load_word(17'h0ABCD);
      n = 2;
      checks++; if (dut.state_q !== LOCKOUT) begin errors++; $display("FAIL lock_ignore_state: got %0d expected %0d", dut.state_q, LOCKOUT); end
      checks++; if (dut.pw_user_q !== 16'h0003) begin errors++; $display("FAIL lock_ignore_user: got %h expected 0003", dut.pw_user_q); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++; if (grant !== 1'b0) begin errors++; $display("FAIL lock_grant: got %b expected 0", grant); end
         if (dut.state_q == LOCKOUT) n++;
         else break;
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL lock_len: got %0d expected 16", n); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL lock_exit_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++; if (dut.fail_cnt_q !== 2'd0) begin errors++; $display("FAIL lock_exit_fail: got %0d expected 0", dut.fail_cnt_q); end
      load_word(17'h0ABCD);
      repeat (3) @(negedge clk);
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL lock_regrant: got %b expected 1", grant); end
      load_word(17'h00000);
   endtask

   task automatic test_ignored_and_abort();
      load_word(17'h15555);
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ign_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++; if (dut.pw_user_q !== 16'hABCD) begin errors++; $display("FAIL ign_user: got %h expected abcd", dut.pw_user_q); end
      repeat (2) @(negedge clk);
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ign_state_later: got %0d expected %0d", dut.state_q, IDLE); end
      load_word(17'h0ABCD);
      @(negedge clk);
      checks++; if (dut.state_q !== MEM_WAIT) begin errors++; $display("FAIL abort_pre: got %0d expected %0d", dut.state_q, MEM_WAIT); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dut.state_q, IDLE); end
      checks++; if (dut.pw_user_q !== 16'h0000) begin errors++; $display("FAIL abort_user: got %h expected 0000", dut.pw_user_q); end
      repeat (5) begin
         @(negedge clk);
         checks++; if (grant !== 1'b0 || wren !== 1'b0) begin errors++; $display("FAIL abort_quiet: got grant=%b wren=%b expected 0 0", grant, wren); end
      end
      checks++; if (ram !== 16'hABCD) begin errors++; $display("FAIL abort_ram: got %h expected abcd", ram); end
   endtask

   initial begin
      test_reset();
      test_mismatch();
      test_match();
      test_change_pw();
      test_lockout();
      test_ignored_and_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
